// File: rtl/lpa_uart_pkg.sv
// Shared constants and types for the simulation UART transmitter (lpa_uart_tx).
// Register offsets, STATUS bit layout, drain FSM states and the finish flag position.
package lpa_uart_pkg;

    localparam logic [4:0] ADDR_TXDATA  = 5'h00;
    localparam logic [4:0] ADDR_STATUS  = 5'h04;
    localparam logic [4:0] ADDR_FINISH  = 5'h08;
    localparam logic [4:0] ADDR_RXDATA  = 5'h0C;
    localparam logic [4:0] ADDR_TXCOUNT = 5'h10;

    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_HALTED_BIT = 2;
    localparam int STATUS_COUNT_LSB  = 8;

    // Bit 7 of an output character tells the console to dump stats and stop.
    localparam int FINISH_BIT = 7;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_SEND,
        DRAIN_GAPW,
        DRAIN_HALT
    } drain_state_t;

    // Assemble the STATUS word from the individual flags and the FIFO fill level.
    function automatic logic [31:0] packStatus(input logic full, input logic empty,
                                               input logic halted, input logic [7:0] count);
        logic [31:0] word;
        word = '0;
        word[STATUS_FULL_BIT]   = full;
        word[STATUS_EMPTY_BIT]  = empty;
        word[STATUS_HALTED_BIT] = halted;
        word[STATUS_COUNT_LSB +: 8] = count;
        return word;
    endfunction

endpackage

// File: rtl/lpa_sync_fifo.sv
// Generic single-clock FIFO with push/pop, full/empty flags and a fill count.
// DEPTH must be a power of two so the pointers wrap naturally.
// i_clear empties the FIFO synchronously and takes priority over push and pop.
module lpa_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rptr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and fill-count bookkeeping; a simultaneous push and pop keeps the count.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lpa_uart_tx.sv
// Simulation UART: bus-mapped TX FIFO drained one character per slot to the
// testbench console, finish-code carrier and console-input proxy.
// Optional feature macro: LPA_UART_TX_STATS_EN adds a readable output-character counter.
module lpa_uart_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP        = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);

    import lpa_uart_pkg::*;

    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_LAST = (GAP > 1) ? (GAP - 2) : 0;

    drain_state_t r_state;
    logic         r_outValid;
    logic [7:0]   r_outCh;
    logic [31:0]  r_gapCnt;
    logic         r_respValid;
    logic [31:0]  r_respRdata;

    logic          w_fifoFull;
    logic          w_fifoEmpty;
    logic [CW-1:0] w_fifoCount;
    logic [7:0]    w_fifoData;
    logic          w_halted;
    logic          w_isTxWrite;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_pushData;
    logic [31:0]   w_rdata;
    logic [31:0]   w_txCount;
    logic          w_unusedWdata;

    assign w_halted    = (r_state == DRAIN_HALT);
    assign w_isTxWrite = req_valid && req_write &&
                         ((req_addr == ADDR_TXDATA) || (req_addr == ADDR_FINISH));
    // Once halted, writes are swallowed so software spinning on the UART never hangs.
    assign req_ready   = !reset || !(w_isTxWrite && w_fifoFull && !w_halted);
    assign w_accept    = req_valid && req_ready;
    assign w_push      = reset && w_accept && w_isTxWrite && !w_halted;
    assign w_pushData  = {(req_addr == ADDR_FINISH), req_wdata[6:0]};
    assign w_unusedWdata = &{1'b0, req_wdata[31:7]};

    // A pop ends the current slot: from IDLE, straight out of SEND when there is
    // no gap, or on the last gap cycle, so strobes land exactly GAP cycles apart.
    assign w_pop = !w_fifoEmpty &&
                   ((r_state == DRAIN_IDLE) ||
                    ((r_state == DRAIN_SEND) && (GAP == 1) && !r_outCh[FINISH_BIT]) ||
                    ((r_state == DRAIN_GAPW) && (r_gapCnt == 32'(GAP_LAST))));

    assign uart_in_valid  = reset && w_accept && !req_write && (req_addr == ADDR_RXDATA);
    assign uart_out_valid = r_outValid;
    assign uart_out_ch    = r_outCh;
    assign resp_valid     = r_respValid;
    assign resp_rdata     = r_respRdata;

    lpa_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_halted),
        .i_push  (w_push),
        .i_wdata (w_pushData),
        .i_pop   (w_pop),
        .o_rdata (w_fifoData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

`ifdef LPA_UART_TX_STATS_EN
    logic [31:0] r_txCount;

    // Count every character strobed out, finish character included; wraps freely.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_txCount <= '0;
        end else if (r_outValid) begin
            r_txCount <= r_txCount + 32'd1;
        end
    end

    assign w_txCount = r_txCount;
`else
    assign w_txCount = '0;
`endif

    // Read data mux; a halted device reports just the halted flag since its FIFO is dead.
    always_comb begin
        w_rdata = '0;
        if (!req_write) begin
            case (req_addr)
                ADDR_STATUS: begin
                    if (w_halted) begin
                        w_rdata = packStatus(1'b0, 1'b0, 1'b1, 8'h00);
                    end else begin
                        w_rdata = packStatus(w_fifoFull, w_fifoEmpty, 1'b0, 8'(w_fifoCount));
                    end
                end
                ADDR_RXDATA:  w_rdata = {24'h0, uart_in_ch};
                ADDR_TXCOUNT: w_rdata = w_txCount;
                default:      w_rdata = '0;
            endcase
        end
    end

    // Registered bus response, one cycle after each accepted request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_respValid <= 1'b0;
            r_respRdata <= '0;
        end else begin
            r_respValid <= w_accept;
            r_respRdata <= w_accept ? w_rdata : 32'h0;
        end
    end

    // Drain FSM: pop a character, strobe it for one cycle, wait out the gap, halt on finish.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= DRAIN_IDLE;
            r_outValid <= 1'b0;
            r_outCh    <= '0;
            r_gapCnt   <= '0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                DRAIN_IDLE: begin
                    if (w_pop) begin
                        r_outValid <= 1'b1;
                        r_outCh    <= w_fifoData;
                        r_state    <= DRAIN_SEND;
                    end
                end
                DRAIN_SEND: begin
                    if (r_outCh[FINISH_BIT]) begin
                        r_state <= DRAIN_HALT;
                    end else if (GAP > 1) begin
                        r_gapCnt <= '0;
                        r_state  <= DRAIN_GAPW;
                    end else if (w_pop) begin
                        r_outValid <= 1'b1;
                        r_outCh    <= w_fifoData;
                    end else begin
                        r_state <= DRAIN_IDLE;
                    end
                end
                DRAIN_GAPW: begin
                    if (r_gapCnt == 32'(GAP_LAST)) begin
                        if (w_pop) begin
                            r_outValid <= 1'b1;
                            r_outCh    <= w_fifoData;
                            r_state    <= DRAIN_SEND;
                        end else begin
                            r_state <= DRAIN_IDLE;
                        end
                    end else begin
                        r_gapCnt <= r_gapCnt + 32'd1;
                    end
                end
                DRAIN_HALT: begin
                    r_state <= DRAIN_HALT;
                end
                default: begin
                    r_state <= DRAIN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpa_uart_tx.sv
// Self-checking bench for lpa_uart_tx: instance A uses GAP=1, instance B a long GAP
// so its FIFO can be filled while the drain is busy. Honours LPA_UART_TX_STATS_EN.
module tb_lpa_uart_tx;

    localparam int GAP_B = 40;

`ifdef LPA_UART_TX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWrite  [2];
    logic [4:0]  reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic        respValid [2];
    logic [31:0] respRdata [2];
    logic        outValid  [2];
    logic [7:0]  outCh     [2];
    logic        inValid   [2];
    logic [7:0]  inCh      [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int logCycA[$];
    int logChA[$];
    int logCycB[$];
    int logChB[$];

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  ch;
        logic        expInValid;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [9];

    lpa_uart_tx #(.FIFO_DEPTH(16), .GAP(1)) dutA (
        .clock(clock), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_rdata(respRdata[0]),
        .uart_out_valid(outValid[0]), .uart_out_ch(outCh[0]),
        .uart_in_valid(inValid[0]), .uart_in_ch(inCh[0])
    );

    lpa_uart_tx #(.FIFO_DEPTH(16), .GAP(GAP_B)) dutB (
        .clock(clock), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_rdata(respRdata[1]),
        .uart_out_valid(outValid[1]), .uart_out_ch(outCh[1]),
        .uart_in_valid(inValid[1]), .uart_in_ch(inCh[1])
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every output strobe with the cycle it was seen in.
    always @(negedge clock) begin
        if (outValid[0] === 1'b1) begin
            logCycA.push_back(cyc);
            logChA.push_back(int'(outCh[0]));
        end
        if (outValid[1] === 1'b1) begin
            logCycB.push_back(cyc);
            logChB.push_back(int'(outCh[1]));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // One bus request held for one cycle; returns combinational and registered results.
    task automatic applyStimulus(input int sel, input logic wr, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic [7:0] ch,
                                 output logic gotReady, output logic gotInValid,
                                 output logic gotRespValid, output logic [31:0] gotRdata,
                                 output int accCyc);
        @(negedge clock);
        reqValid[sel] = 1'b1;
        reqWrite[sel] = wr;
        reqAddr[sel]  = addr;
        reqWdata[sel] = wdata;
        inCh[sel]     = ch;
        accCyc        = cyc;
        #1;
        gotReady   = reqReady[sel];
        gotInValid = inValid[sel];
        @(negedge clock);
        gotRespValid  = respValid[sel];
        gotRdata      = respRdata[sel];
        reqValid[sel] = 1'b0;
    endtask

    task automatic busCheck(input string name, input int sel, input logic wr,
                            input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expRdata);
        logic rdy, inv, rv;
        logic [31:0] rd;
        int acc;
        applyStimulus(sel, wr, addr, wdata, 8'h00, rdy, inv, rv, rd, acc);
        checkOutput({name, ".ready"}, 32'(rdy), 32'd1);
        checkOutput({name, ".rdata"}, rd, expRdata);
    endtask

    task automatic driveWrite(input int sel, input logic [4:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        reqValid[sel] = 1'b1;
        reqWrite[sel] = 1'b1;
        reqAddr[sel]  = addr;
        reqWdata[sel] = wdata;
    endtask

    task automatic idleBus(input int sel);
        @(negedge clock);
        reqValid[sel] = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic rdy, inv, rv;
        logic [31:0] rd;
        int acc, n, waited;

        for (int s = 0; s < 2; s++) begin
            reqValid[s] = 1'b0;
            reqWrite[s] = 1'b0;
            reqAddr[s]  = '0;
            reqWdata[s] = '0;
            inCh[s]     = 8'hff;
        end

        vecs[0] = '{1'b0, 5'h04, 32'h0,    8'h00, 1'b0, 32'h0000_0002};
        vecs[1] = '{1'b0, 5'h0C, 32'h0,    8'h5A, 1'b1, 32'h0000_005A};
        vecs[2] = '{1'b0, 5'h0C, 32'h0,    8'hFF, 1'b1, 32'h0000_00FF};
        vecs[3] = '{1'b0, 5'h10, 32'h0,    8'h00, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 5'h14, 32'h0,    8'h00, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 5'h18, 32'hDEAD, 8'h00, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 5'h0C, 32'h77,   8'h33, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 5'h00, 32'h0,    8'h00, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 5'h04, 32'h0,    8'h00, 1'b0, 32'h0000_0002};

        // Reset values while reset is held low.
        repeat (3) @(negedge clock);
        checkOutput("rst.req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("rst.resp_valid", 32'(respValid[0]), 32'd0);
        checkOutput("rst.resp_rdata", respRdata[0], 32'd0);
        checkOutput("rst.out_valid", 32'(outValid[0]), 32'd0);
        checkOutput("rst.out_ch", 32'(outCh[0]), 32'd0);
        checkOutput("rst.in_valid", 32'(inValid[0]), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single-request register vectors on instance A.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ch,
                          rdy, inv, rv, rd, acc);
            checkOutput($sformatf("vec%0d.ready", i), 32'(rdy), 32'd1);
            checkOutput($sformatf("vec%0d.in_valid", i), 32'(inv), 32'(vecs[i].expInValid));
            checkOutput($sformatf("vec%0d.resp_valid", i), 32'(rv), 32'd1);
            checkOutput($sformatf("vec%0d.rdata", i), rd, vecs[i].expRdata);
        end
        @(negedge clock);
        checkOutput("vec.resp_valid_drops", 32'(respValid[0]), 32'd0);
        checkOutput("vec.in_valid_idle", 32'(inValid[0]), 32'd0);

        // Back-to-back TXDATA writes with GAP=1.
        logCycA.delete();
        logChA.delete();
        driveWrite(0, 5'h00, 32'h0000_0048);
        n = cyc;
        driveWrite(0, 5'h00, 32'hFFFF_FF69);
        idleBus(0);
        repeat (6) @(negedge clock);
        checkOutput("b2b.count", 32'(logCycA.size()), 32'd2);
        checkOutput("b2b.cyc0", 32'((logCycA.size() > 0) ? logCycA[0] - n : -1), 32'd2);
        checkOutput("b2b.ch0", 32'((logChA.size() > 0) ? logChA[0] : -1), 32'h48);
        checkOutput("b2b.cyc1", 32'((logCycA.size() > 1) ? logCycA[1] - n : -1), 32'd3);
        checkOutput("b2b.ch1", 32'((logChA.size() > 1) ? logChA[1] : -1), 32'h69);

        // FINISH followed immediately by TXDATA: only the finish character appears.
        logCycA.delete();
        logChA.delete();
        driveWrite(0, 5'h08, 32'h0000_0041);
        n = cyc;
        driveWrite(0, 5'h00, 32'h0000_0042);
        idleBus(0);
        repeat (10) @(negedge clock);
        checkOutput("fin.count", 32'(logCycA.size()), 32'd1);
        checkOutput("fin.ch", 32'((logChA.size() > 0) ? logChA[0] : -1), 32'hC1);
        checkOutput("fin.cyc", 32'((logCycA.size() > 0) ? logCycA[0] - n : -1), 32'd2);
        busCheck("fin.status", 0, 1'b0, 5'h04, 32'h0, 32'h0000_0004);
        applyStimulus(0, 1'b1, 5'h00, 32'h33, 8'h00, rdy, inv, rv, rd, acc);
        checkOutput("halt.write_ready", 32'(rdy), 32'd1);
        checkOutput("halt.write_resp", 32'(rv), 32'd1);
        repeat (5) @(negedge clock);
        checkOutput("halt.no_output", 32'(logCycA.size()), 32'd1);

        // Reset leaves HALT and the device works again.
        pulseReset();
        busCheck("rst2.status", 0, 1'b0, 5'h04, 32'h0, 32'h0000_0002);
        logCycA.delete();
        logChA.delete();
        applyStimulus(0, 1'b1, 5'h00, 32'h55, 8'h00, rdy, inv, rv, rd, acc);
        repeat (4) @(negedge clock);
        checkOutput("rst2.out_ch", 32'((logChA.size() > 0) ? logChA[0] : -1), 32'h55);
        checkOutput("rst2.out_cyc", 32'((logCycA.size() > 0) ? logCycA[0] - acc : -1), 32'd2);

        // Instance B: one character occupies the long gap while 16 more fill the FIFO.
        logCycB.delete();
        logChB.delete();
        applyStimulus(1, 1'b1, 5'h00, 32'h01, 8'h00, rdy, inv, rv, rd, acc);
        for (int i = 0; i < 16; i++) begin
            driveWrite(1, 5'h00, 32'(8'h10 + i));
        end
        idleBus(1);
        busCheck("ovf.status_full", 1, 1'b0, 5'h04, 32'h0, 32'h0000_1001);
        @(negedge clock);
        reqValid[1] = 1'b1;
        reqWrite[1] = 1'b1;
        reqAddr[1]  = 5'h00;
        reqWdata[1] = 32'h7E;
        #1;
        checkOutput("ovf.ready_low", 32'(reqReady[1]), 32'd0);
        waited = 0;
        while (reqReady[1] !== 1'b1 && waited < 200) begin
            @(negedge clock);
            #1;
            waited++;
        end
        checkOutput("ovf.accepted_in_time", 32'(waited < 200), 32'd1);
        idleBus(1);
        busCheck("ovf.status_refill", 1, 1'b0, 5'h04, 32'h0, 32'h0000_1001);
        waited = 0;
        while (logCycB.size() < 3 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("gap.strobes_in_time", 32'(logCycB.size() >= 3), 32'd1);
        checkOutput("gap.first_latency", 32'((logCycB.size() > 0) ? logCycB[0] - acc : -1), 32'd2);
        checkOutput("gap.spacing01", 32'((logCycB.size() > 1) ? logCycB[1] - logCycB[0] : -1), 32'(GAP_B));
        checkOutput("gap.spacing12", 32'((logCycB.size() > 2) ? logCycB[2] - logCycB[1] : -1), 32'(GAP_B));
        checkOutput("gap.ch0", 32'((logChB.size() > 0) ? logChB[0] : -1), 32'h01);
        checkOutput("gap.ch1", 32'((logChB.size() > 1) ? logChB[1] : -1), 32'h10);
        checkOutput("gap.ch2", 32'((logChB.size() > 2) ? logChB[2] : -1), 32'h11);

        // Reset while B still holds a backlog: everything is discarded.
        pulseReset();
        logCycB.delete();
        logChB.delete();
        busCheck("midrst.status", 1, 1'b0, 5'h04, 32'h0, 32'h0000_0002);
        busCheck("midrst.txcount", 1, 1'b0, 5'h10, 32'h0, 32'h0);
        repeat (50) @(negedge clock);
        checkOutput("midrst.no_output", 32'(logCycB.size()), 32'd0);

        // Character counter on A after five characters.
        logCycA.delete();
        logChA.delete();
        for (int i = 0; i < 5; i++) begin
            driveWrite(0, 5'h00, 32'(8'h61 + i));
        end
        idleBus(0);
        repeat (8) @(negedge clock);
        checkOutput("stats.strobes", 32'(logCycA.size()), 32'd5);
        busCheck("stats.txcount", 0, 1'b0, 5'h10, 32'h0, STATS_ON ? 32'd5 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpa_uart_tx.md
# lpa_uart_tx

Simulation UART device inside SimTop, directly upstream of the testbench console. It accepts register accesses from the SoC peripheral bus, buffers transmit characters in a FIFO and drains them one per slot onto uart_out_valid/uart_out_ch. It also carries the end-of-run finish code: bit 7 set means finish, and the testbench then dumps performance data and stops. It proxies console-input reads to uart_in_valid/uart_in_ch.

## Interface
Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2
- GAP, 1, cycles per output slot (≥1); 1 = back-to-back characters

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  bus request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  5  byte offset
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data; 0 for writes
- uart_out_valid  out  1  character strobe to testbench
- uart_out_ch  out  8  character; bit 7 = finish flag
- uart_in_valid  out  1  console-read strobe
- uart_in_ch  in  8  console character; 0xff = none

## Operation
Register map:
- 0x00 TXDATA, W: push {1'b0, wdata[6:0]}.
- 0x04 STATUS, R: bit0 full, bit1 empty, bit2 halted, bits[15:8] count.
- 0x08 FINISH, W: push {1'b1, wdata[6:0]}.
- 0x0C RXDATA, R: uart_in_valid pulses in the accept cycle; rdata = {24'h0, uart_in_ch}.
- 0x10 TXCOUNT, R: see Configuration.
- Other offsets: reads return 0, writes are ignored.

Request handling:
- req_ready drops only when a TXDATA or FINISH write is presented while the FIFO is full.
- Reads and ignored writes are always ready.

Drain FSM, states IDLE, SEND, GAPW, HALT:
- IDLE: FIFO non-empty → pop and go to SEND.
- SEND: uart_out_valid=1 for exactly one cycle with the popped character. If the character's bit7=1 → HALT. Else if GAP>1 → GAPW. Else → IDLE.
- GAPW: count GAP-1 cycles, then → IDLE.
- HALT: terminal. No further output. Writes are still accepted and discarded, so software never hangs. STATUS.halted=1.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, uart_out_valid=0, uart_out_ch=0, uart_in_valid=0; FIFO empty; FSM in IDLE.
- Reset mid-operation discards FIFO contents and any in-flight character, including HALT state.
- resp_valid and resp_rdata are registered: they appear 1 cycle after acceptance. Back-to-back requests give back-to-back responses.
- Write-to-output latency, empty FIFO and FSM in IDLE: accept at cycle N, pop at N+1, uart_out_valid at N+2.
- Simultaneous push and pop:
  - FIFO not full: both occur and count is unchanged.
  - FIFO full: the push is refused (req_ready=0) even if a pop happens in the same cycle.
  - req_ready is combinational from the current full flag.
- Count is $clog2(FIFO_DEPTH+1) bits wide. Read and write pointers wrap modulo FIFO_DEPTH.
- STATUS reflects state at the accept cycle, before that cycle's push or pop.

## Configuration
- LPA_UART_TX_STATS_EN defined: 32-bit counter of characters output, including the finish character. Wraps at 2^32, clears on reset, readable at TXCOUNT.
- Not defined: no counter logic; TXCOUNT reads 0.

## Structure
- Package lpa_uart_pkg holds:
  - register offset constants
  - STATUS bit positions
  - drain-state enum
  - FINISH_BIT = 7
- Sub-module lpa_sync_fifo: generic DEPTH/WIDTH synchronous FIFO with push, pop, full, empty and count. The FIFO is instantiated at width 8.

## Test plan
- Reset release, write 0x48 then 0x69 to TXDATA on consecutive cycles, GAP=1 → uart_out_ch 0x48 at N+2 and 0x69 at N+3, each with a one-cycle valid.
- GAP=4, three writes → output strobes exactly 4 cycles apart.
- 17 writes with FIFO_DEPTH=16 and output blocked by an earlier pending character → req_ready low on the overflow write. It is accepted once a pop frees a slot, and STATUS.count reads 16 while stalled.
- Write 0x41 to FINISH, then 0x42 to TXDATA → uart_out_ch=0xC1 once, 0x42 never appears, STATUS reads 0x4 with count bits 0.
- Read RXDATA with uart_in_ch=0xff → uart_in_valid single pulse, resp_rdata=0x000000ff one cycle later.
- With LPA_UART_TX_STATS_EN: 5 characters then read TXCOUNT → 5. Assert reset mid-burst → TXCOUNT 0 and FIFO empty.
